// File: rtl/seq_bin_to_bcd_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
//   start   : one-cycle request pulse (master -> slave)
//   bin_in  : unsigned magnitude to convert, BIN_W bits (master -> slave)
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle pulse when new digits are valid (slave -> master)
//   bcd_u/bcd_t/bcd_h/bcd_th/bcd_tt : units .. ten-thousands digits (slave -> master)
interface seq_bin_to_bcd_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [3:0]       bcd_u;
  logic [3:0]       bcd_t;
  logic [3:0]       bcd_h;
  logic [3:0]       bcd_th;
  logic [3:0]       bcd_tt;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_u, bcd_t, bcd_h, bcd_th, bcd_tt
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_u, bcd_t, bcd_h, bcd_th, bcd_tt
  );
endinterface

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock,
// MSB first). A start pulse in IDLE latches bin_in; BIN_W clocks later the
// five digit registers update and done pulses for one cycle.
//   clock : rising-edge system clock
//   reset : asynchronous, active-high reset
//   bus   : seq_bin_to_bcd_if.slave (start, bin_in, busy, done, five digits)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; digit outputs hold the last result
// SHIFT | one add-3 / shift step per clock, BIN_W steps in total
module seq_bin_to_bcd #(
  parameter int BIN_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  seq_bin_to_bcd_if.slave   bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] shift_q;
  logic [19:0]      scratch_q;
  logic [19:0]      scratch_adj;
  logic [19:0]      scratch_next;
  logic [CNT_W-1:0] cnt_q;
  logic [19:0]      digits_q;
  logic             done_q;
  logic             load;
  logic             last_shift;

  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[i*4 +: 4] >= 4'd5)
        r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Shifting the adjusted scratch left and pulling in the next input MSB.
  assign scratch_adj  = add3(scratch_q);
  assign scratch_next = (scratch_adj << 1) | 20'(shift_q[BIN_W-1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    last_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          last_shift = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_shift;
      if (load) begin
        shift_q   <= bus.bin_in;
        scratch_q <= '0;
        cnt_q     <= CNT_W'(BIN_W);
      end else if (state_q == SHIFT) begin
        shift_q   <= shift_q << 1;
        scratch_q <= scratch_next;
        cnt_q     <= cnt_q - CNT_W'(1);
        // Outputs only ever see the completed value, never partial scratch.
        if (last_shift)
          digits_q <= scratch_next;
      end
    end
  end

  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = done_q;
  assign bus.bcd_u  = digits_q[3:0];
  assign bus.bcd_t  = digits_q[7:4];
  assign bus.bcd_h  = digits_q[11:8];
  assign bus.bcd_th = digits_q[15:12];
  assign bus.bcd_tt = digits_q[19:16];
endmodule

// File: doc/seq_bin_to_bcd.md
SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

Interface
REQ-001 Parameter SHALL be: BIN_W, default 14, width of the unsigned binary input (supported range 1..16).
REQ-002 Port SHALL be: clock  input  1  rising-edge system clock.
REQ-003 Port SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-004 Port SHALL be: start  input  1  one-cycle request pulse (from pushbutton_detector or the multiplier's done).
REQ-005 Port SHALL be: bin_in  input  BIN_W  unsigned magnitude to convert (multiplier product).
REQ-006 Port SHALL be: busy  output  1  high while a conversion is in progress.
REQ-007 Port SHALL be: done  output  1  one-cycle pulse when new digits become valid.
REQ-008 Port SHALL be: bcd_u  output  4  units digit.
REQ-009 Port SHALL be: bcd_t  output  4  tens digit.
REQ-010 Port SHALL be: bcd_h  output  4  hundreds digit.
REQ-011 Port SHALL be: bcd_th  output  4  thousands digit.
REQ-012 Port SHALL be: bcd_tt  output  4  ten-thousands digit; all five feed the scroller.

Function
REQ-013 Conversion SHALL use the iterative shift-add-3 (double-dabble) algorithm, one input bit per clock, MSB first.
REQ-014 FSM SHALL have exactly two states, IDLE and SHIFT, encoded internally.
REQ-015 In IDLE, start=1 at a rising edge SHALL latch bin_in into a shift register, clear the 20-bit BCD scratch, load bit counter with BIN_W, enter SHIFT.
REQ-016 In SHIFT, each edge SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift_reg} left by one, decrement the counter.
REQ-017 On the edge that performs the BIN_W-th shift, the FSM SHALL return to IDLE, copy the final scratch into the five output registers, and set done=1.
REQ-018 done SHALL be high for exactly one cycle (the cycle after the final shift) and 0 otherwise.
REQ-019 Latency SHALL be exactly BIN_W cycles from the edge sampling start to the edge raising done (14 for default).
REQ-020 busy SHALL be 1 in SHIFT, 0 in IDLE (busy=0 during the done cycle).
REQ-021 start while in SHIFT SHALL be ignored; no queuing, current conversion unaffected.
REQ-022 start in the done cycle SHALL be accepted (state is IDLE), enabling back-to-back conversions every BIN_W+1 cycles.
REQ-023 bin_in changes after the latching edge SHALL NOT affect the conversion in progress.
REQ-024 Output digits SHALL hold their last completed value until the next done; they SHALL NOT show intermediate scratch values.
REQ-025 Every output digit SHALL be in 0..9; for BIN_W=14 bcd_tt SHALL be 0 or 1.
REQ-026 Scratch adjustment SHALL not overflow: 20-bit scratch covers all inputs up to 2^16-1 = 65535.

Reset
REQ-027 reset=1 SHALL immediately, regardless of clock, force state IDLE, busy=0, done=0, all five digit outputs 0, counter and scratch 0.
REQ-028 reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow the reset release.
REQ-029 After reset deasserts, the first start sampled SHALL begin a normal conversion.

Verification
REQ-030 Reset, then start with bin_in=0 -> busy high 14 cycles, done pulse on cycle 14, digits 0,0,0,0,0.
REQ-031 start with bin_in=16383 -> after 14 cycles bcd_tt..bcd_u = 1,6,3,8,3; done one cycle wide.
REQ-032 start with bin_in=9999, then a second start 5 cycles later with bin_in=1 -> second start ignored, result 0,9,9,9,9, exactly one done.
REQ-033 start bin_in=255, assert start again in the done cycle with bin_in=1234 -> first result 0,0,2,5,5, second result 0,1,2,3,4, 15 cycles after the first done.
REQ-034 Complete 9999 conversion, start bin_in=42, assert reset at cycle 7 -> digits go to 0 asynchronously, busy=0, no done afterwards; next start with 42 yields 0,0,0,4,2.
REQ-035 Random sweep of 1000 bin_in values in 0..16383 -> each output matches a decimal reference model; digits stable between done pulses.
